// File: rtl/imm_ext_stage_pkg.sv
// rtl/imm_ext_stage_pkg.sv - shared op codes and default widths for the immediate-extension stage
package imm_ext_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IMM_W_DEF  = 16;
    localparam int JIDX_W_DEF = 26;
    localparam int OP_W_DEF   = 3;
    localparam int TAG_W_DEF  = 5;

    // Codes 0..2 keep their legacy values; 5..7 are undefined and flag an error.
    typedef enum logic [2:0] {
        EXT_ZERO    = 3'd0,
        EXT_SIGNED  = 3'd1,
        EXT_HIGHPOS = 3'd2,
        EXT_BRANCH  = 3'd3,
        EXT_JUMP    = 3'd4
    } ext_op_e;

endpackage

// File: rtl/imm_ext_stage_ext_core.sv
// rtl/imm_ext_stage_ext_core.sv - combinational op to extended-immediate mapping
// Ports: op (extension code), imm (jump index, low IMM_W bits are the I-type immediate),
//        pc4 (PC+4, jump mode), result (extended value), err (undefined op)
module ext_core
    import imm_ext_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMM_W  = IMM_W_DEF,
    parameter int JIDX_W = JIDX_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic [OP_W-1:0]   op,
    input  logic [JIDX_W-1:0] imm,
    input  logic [DATA_W-1:0] pc4,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    // Upper PC bits kept in jump mode; written as a mask so DATA_W == JIDX_W+2 also works.
    localparam logic [DATA_W-1:0] JUMP_HI_MASK = ~((DATA_W'(1) << (JIDX_W + 2)) - DATA_W'(1));

    logic [IMM_W-1:0]  imm16;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] idx_wide;

    assign imm16    = imm[IMM_W-1:0];
    assign sext     = {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};
    assign idx_wide = {{(DATA_W-JIDX_W){1'b0}}, imm};

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            EXT_ZERO:    result = {{(DATA_W-IMM_W){1'b0}}, imm16};
            EXT_SIGNED:  result = sext;
            EXT_HIGHPOS: result = {imm16, {(DATA_W-IMM_W){1'b0}}};
            EXT_BRANCH:  result = sext << 2;
            EXT_JUMP:    result = (pc4 & JUMP_HI_MASK) | (idx_wide << 2);
            default:     err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// rtl/imm_ext_stage.sv - registered immediate extension with 2-entry skid buffer and flush
// Ports: clk, rstn (async active-low), flush; in_valid/in_ready/in_op/in_imm/in_pc4/in_tag (decode side);
//        out_valid/out_ready/out_imm/out_tag/out_err (execute side, zeroed when out_valid=0)
module imm_ext_stage
    import imm_ext_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMM_W  = IMM_W_DEF,
    parameter int JIDX_W = JIDX_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [JIDX_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    logic [1:0]        count;
    logic [DATA_W-1:0] head_imm, tail_imm;
    logic [TAG_W-1:0]  head_tag, tail_tag;
    logic              head_err, tail_err;

    logic [DATA_W-1:0] ext_imm;
    logic              ext_err;
    logic              push, pop;

    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .JIDX_W (JIDX_W),
        .OP_W   (OP_W)
    ) u_ext_core (
        .op     (in_op),
        .imm    (in_imm),
        .pc4    (in_pc4),
        .result (ext_imm),
        .err    (ext_err)
    );

    // Both flags come from the registered count only, so in_ready never depends on out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count    <= 2'd0;
            head_imm <= '0;
            head_tag <= '0;
            head_err <= 1'b0;
            tail_imm <= '0;
            tail_tag <= '0;
            tail_err <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_imm <= ext_imm;
                        head_tag <= in_tag;
                        head_err <= ext_err;
                    end else begin
                        tail_imm <= ext_imm;
                        tail_tag <= in_tag;
                        tail_err <= ext_err;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_imm <= tail_imm;
                    head_tag <= tail_tag;
                    head_err <= tail_err;
                    count    <= count - 2'd1;
                end
                // Push and pop together only happens at count=1: the new entry replaces the head.
                2'b11: begin
                    head_imm <= ext_imm;
                    head_tag <= in_tag;
                    head_err <= ext_err;
                end
                default: ;
            endcase
        end
    end

    assign out_imm = out_valid ? head_imm : '0;
    assign out_tag = out_valid ? head_tag : '0;
    assign out_err = out_valid & head_err;

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb/tb_imm_ext_stage.sv - self-checking bench for imm_ext_stage
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [25:0] in_imm;
    logic [31:0] in_pc4;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  tag;
        logic        err;
    } ent_t;

    ent_t q[$];
    logic last_push = 1'b0;

    always #5 clk = ~clk;

    imm_ext_stage dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_imm    (in_imm),
        .in_pc4    (in_pc4),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension written from the arithmetic meaning of each mode.
    function automatic logic [31:0] model_ext(input int op, input logic [25:0] idx, input logic [31:0] pc4);
        longint v16;
        longint s;
        logic [31:0] r;
        v16 = longint'(idx) % 65536;
        s   = (v16 >= 32768) ? v16 - 65536 : v16;
        case (op)
            0:       r = 32'(v16);
            1:       r = 32'(s);
            2:       r = 32'(v16 * 65536);
            3:       r = 32'(s * 4);
            4:       r = (pc4 & 32'hF000_0000) | 32'(longint'(idx) * 4);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Model of the buffer: a queue of at most two entries.
    always @(negedge rstn) q.delete();

    always @(posedge clk) begin
        bit can_take, pop_now, push_now;
        ent_t e;
        last_push = 1'b0;
        if (rstn === 1'b1) begin
            can_take  = (q.size() < 2);
            pop_now   = (q.size() > 0) && out_ready;
            push_now  = in_valid && can_take && !flush;
            last_push = in_valid && can_take;
            if (flush) begin
                q.delete();
            end else begin
                if (pop_now) q.delete(0);
                if (push_now) begin
                    e.imm = model_ext(int'(in_op), in_imm, in_pc4);
                    e.tag = in_tag;
                    e.err = (in_op > 3'd4);
                    q.push_back(e);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("cyc_in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() != 0) begin
            chk("cyc_out_imm", out_imm, q[0].imm);
            chk("cyc_out_tag", 32'(out_tag), 32'(q[0].tag));
            chk("cyc_out_err", 32'(out_err), 32'(q[0].err));
        end else begin
            chk("cyc_idle_zero", {out_imm[31:1], out_imm[0] | out_err}, 32'd0);
            chk("cyc_idle_tag", 32'(out_tag), 32'd0);
        end
    end

    task automatic send(input logic [2:0] op, input logic [25:0] imm, input logic [31:0] pc4,
                        input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_imm   = imm;
        in_pc4   = pc4;
        in_tag   = tag;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (last_push) break;
        end
        chk("send_accepted", 32'(last_push), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic mode(input string name, input logic [2:0] op, input logic [25:0] imm,
                        input logic [31:0] pc4, input logic [4:0] tag,
                        input logic [31:0] exp_imm, input logic exp_err);
        send(op, imm, pc4, tag);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_imm"}, out_imm, exp_imm);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        chk({name, "_err"}, 32'(out_err), 32'(exp_err));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] got[$];

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_imm = '0; in_pc4 = '0; in_tag = '0;
        idle(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Extension modes with hand-computed results.
        mode("signed",  3'd1, 26'h0008001, 32'h0, 5'd1, 32'hFFFF8001, 1'b0);
        mode("zero",    3'd0, 26'h0008001, 32'h0, 5'd2, 32'h00008001, 1'b0);
        mode("highpos", 3'd2, 26'h0001234, 32'h0, 5'd3, 32'h12340000, 1'b0);
        mode("branch",  3'd3, 26'h000FFFF, 32'h0, 5'd4, 32'hFFFFFFFC, 1'b0);
        mode("branchp", 3'd3, 26'h0007FFF, 32'h0, 5'd5, 32'h0001FFFC, 1'b0);
        mode("jump",    3'd4, 26'h0000100, 32'h4000_0010, 5'd6, 32'h40000400, 1'b0);
        mode("undef",   3'd6, 26'h0001234, 32'h0, 5'd7, 32'h00000000, 1'b1);
        mode("after_undef", 3'd1, 26'h0000005, 32'h0, 5'd8, 32'h00000005, 1'b0);
        idle(3);

        // Backpressure: tag 3 must be held upstream until space frees.
        out_ready = 1'b0;
        send(3'd0, 26'h11, 32'h0, 5'd1);
        send(3'd0, 26'h22, 32'h0, 5'd2);
        in_valid = 1'b1; in_op = 3'd0; in_imm = 26'h33; in_tag = 5'd3;
        idle(3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head_tag", 32'(out_tag), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_tag);
            @(posedge clk);
            #1;
            if (last_push) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++)
            chk("bp_order", 32'(got[i]), 32'(i + 1));

        // Sustained push+pop at count=1.
        send(3'd0, 26'h40, 32'h0, 5'd10);
        for (int i = 1; i <= 10; i++) begin
            send(3'd1, 26'(i), 32'h0, 5'(10 + i));
            @(negedge clk);
            chk("pp_tag", 32'(out_tag), 32'(10 + i));
            chk("pp_in_ready", 32'(in_ready), 32'd1);
        end
        idle(3);

        // Flush at count=2 and at count=1, each with a same-cycle input.
        out_ready = 1'b0;
        send(3'd2, 26'h1111, 32'h0, 5'd20);
        send(3'd2, 26'h2222, 32'h0, 5'd21);
        in_valid = 1'b1; in_op = 3'd2; in_imm = 26'h3333; in_tag = 5'd22; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", 32'(out_valid), 32'd0);
        send(3'd2, 26'h4444, 32'h0, 5'd23);
        in_valid = 1'b1; in_op = 3'd2; in_imm = 26'h5555; in_tag = 5'd24; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("flush_quiet", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset while holding two entries.
        out_ready = 1'b0;
        send(3'd2, 26'h1234, 32'h0, 5'd30);
        send(3'd2, 26'h5678, 32'h0, 5'd31);
        chk("prerst_in_ready", 32'(in_ready), 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_imm", out_imm, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
